// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the single register-file write port (four sources).
// Optional: define WB_ARB_ZERO_FILTER_EN to suppress write strobes to address 0.
module wb_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic [4*ADDR_W-1:0]   req_addr,
    input  logic [4*DATA_W-1:0]   req_data,
    input  logic                  stall,
    output logic [3:0]            gnt,
    output logic [1:0]            sel,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data
);

    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        sel_q, sel_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic [1:0]        win;
    logic              found;
    logic              xfer;
    logic [1:0]        idx;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    // Scan starting at the pointer; first requester found wins.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (win == 2'(i)) begin
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign xfer = found && !stall && !rst;

    always_comb begin
        gnt = 4'b0000;
        if (xfer) begin
            gnt[win] = 1'b1;
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (!stall) begin
            wr_en_d = 1'b0;
            if (found) begin
                ptr_d     = win + 2'd1;
                sel_d     = win;
                wr_addr_d = win_addr;
                wr_data_d = win_data;
`ifdef WB_ARB_ZERO_FILTER_EN
                wr_en_d   = (win_addr != '0);
`else
                wr_en_d   = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            sel_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign sel     = sel_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized bench for wb_port_arbiter against a
// round-robin reference model.
module tb_wb_port_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   req = 4'b0;
    logic [19:0]  req_addr = '0;
    logic [127:0] req_data = '0;
    logic         stall = 1'b0;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [31:0]  wr_data;

    int total = 0;
    int bad   = 0;

    logic [4:0]  a[4];
    logic [31:0] d[4];

    int          m_ptr;
    int          m_sel;
    logic        m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    wb_port_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
        .req_data(req_data), .stall(stall), .gnt(gnt), .sel(sel),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int winner();
        for (int k = 0; k < 4; k++) begin
            if (req[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_sel = 0; m_en = 1'b0; m_addr = '0; m_data = '0;
    endtask

    task automatic drive(input logic [3:0] r, input logic s);
        req = r;
        stall = s;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*5 +: 5]   = a[i];
            req_data[i*32 +: 32] = d[i];
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".sel"}, 64'(sel), 64'(m_sel));
        check({tag, ".wr_en"}, 64'(wr_en), 64'(m_en));
        check({tag, ".wr_addr"}, 64'(wr_addr), 64'(m_addr));
        check({tag, ".wr_data"}, 64'(wr_data), 64'(m_data));
    endtask

    // Inputs already driven: check grant, clock, advance model, check outputs.
    task automatic step(input string tag);
        int w;
        logic [3:0] eg;
        #1;
        w = winner();
        eg = (w >= 0 && !stall) ? 4'(1 << w) : 4'b0;
        check({tag, ".gnt"}, 64'(gnt), 64'(eg));
        @(posedge clk);
        if (!stall) begin
            if (w >= 0) begin
                m_sel  = w;
                m_addr = a[w];
                m_data = d[w];
`ifdef WB_ARB_ZERO_FILTER_EN
                m_en   = (a[w] != 5'd0);
`else
                m_en   = 1'b1;
`endif
                m_ptr  = (w + 1) % 4;
            end else begin
                m_en = 1'b0;
            end
        end
        #1;
        check_regs(tag);
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        check_regs("rst_pulse");
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            a[i] = 5'(i + 1);
            d[i] = 32'hA000_0000 + 32'(i);
        end
        model_reset();
        #1 rst = 1'b1;
        drive(4'b1111, 1'b0);
        #2;
        check("reset.gnt", 64'(gnt), 64'd0);
        check_regs("reset");
        @(posedge clk);
        #1;
        check("reset_hold.gnt", 64'(gnt), 64'd0);
        check_regs("reset_hold");
        rst = 1'b0;

        // Single request.
        a[0] = 5'd8; d[0] = 32'h1234_5678;
        drive(4'b0001, 1'b0);
        step("single");
        drive(4'b0000, 1'b0);
        step("idle");

        // All requesting from reset: rotate 0,1,2,3 then wrap.
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 1'b0);
            step($sformatf("rr%0d", i));
        end

        // Pointer at 2 with sources 0 and 1 requesting.
        pulse_reset();
        drive(4'b0010, 1'b0);
        step("ptr2_setup");
        drive(4'b0011, 1'b0);
        step("ptr2_a");
        drive(4'b0010, 1'b0);
        step("ptr2_b");

        // Stall freezes a presented write.
        a[2] = 5'd17; d[2] = 32'hDEAD_BEEF;
        drive(4'b0001, 1'b0);
        step("pre_stall");
        for (int i = 0; i < 3; i++) begin
            drive(4'b0100, 1'b1);
            step($sformatf("stall%0d", i));
        end
        drive(4'b0100, 1'b0);
        step("unstall");

        // Asynchronous reset while a write to r31 is presented.
        a[0] = 5'd31; d[0] = 32'hCAFE_F00D;
        drive(4'b0001, 1'b0);
        step("pre_async");
        drive(4'b1111, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async.gnt", 64'(gnt), 64'd0);
        model_reset();
        check_regs("async");
        rst = 1'b0;
        step("after_async");

        // Address 0 write (filtered only when the option is built in).
        pulse_reset();
        a[1] = 5'd0; d[1] = 32'h0BAD_0BAD;
        drive(4'b0010, 1'b0);
        step("zero_addr");
        drive(4'b0100, 1'b0);
        step("zero_next");

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 4; i++) begin
                a[i] = 5'($urandom_range(0, 31));
                d[i] = $urandom;
            end
            drive(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
            step($sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Round-robin arbiter that shares the single register-file write port between four requesters. It drives the 2-bit select of the 5-bit write-address mux and the matching data path. It registers the winning address and data into one write per cycle. It sits between the execute/memory/link/CP0 result sources and the register file. Fairness comes from a rotating priority pointer, and a stall input freezes the port.

## Interface
Parameters:
- DATA_W, 32, width of write data per requester
- ADDR_W, 5, width of register address per requester

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  4  request per source; req[i] stays high until granted
- req_addr  input  4*ADDR_W  packed addresses; source i at [i*ADDR_W +: ADDR_W]
- req_data  input  4*DATA_W  packed data; source i at [i*DATA_W +: DATA_W]
- stall  input  1  register file busy; no grant while high
- gnt  output  4  one-hot grant, combinational; a transfer occurs when req[i] & gnt[i]
- sel  output  2  registered index of the last winner; drives the address/data mux select
- wr_en  output  1  registered write strobe
- wr_addr  output  ADDR_W  registered write address
- wr_data  output  DATA_W  registered write data

## Operation
- State: rotating pointer ptr[1:0] (highest-priority source) and the output registers.
- Arbitration is combinational. It scans sources ptr, ptr+1, ptr+2, ptr+3 (mod 4) and selects the first with req=1.
- gnt is one-hot on the winner and all-zero when no request is pending or stall=1.
- On a clock edge with a transfer:
  - sel <= winner
  - wr_addr <= winner's address
  - wr_data <= winner's data
  - wr_en <= 1
  - ptr <= winner+1 (mod 4; winner 3 wraps to 0)
- On an edge with no transfer and stall=0: wr_en <= 0; sel, wr_addr, wr_data and ptr hold.
- stall=1:
  - gnt=0
  - wr_en, sel, wr_addr, wr_data and ptr all hold their values, so a pending write is presented until stall drops.
- Simultaneous requests: exactly one grant per cycle. Losers keep req high and win within at most 3 further non-stalled cycles.
- A requester that drops req before it is granted is simply skipped. There is no error.
- Reset mid-operation: all registers clear immediately, asynchronously. Any in-flight write is discarded, and requesters must re-present after reset.

## Timing
- Reset values:
  - gnt=0 (forced while rst high)
  - sel=0
  - wr_en=0
  - wr_addr=0
  - wr_data=0
  - ptr=0
- Grant is same-cycle as request (combinational from req, ptr, stall).
- Write latency is 1 cycle: a transfer at edge N appears on wr_* after edge N, and wr_en stays high for exactly one cycle unless stall holds it.
- Throughput is one write per non-stalled cycle.
- The first arbitration after reset favours source 0.

## Configuration
- WB_ARB_ZERO_FILTER_EN
  - Defined: a granted request with address 0 is consumed normally (gnt pulses, ptr advances, sel/wr_addr/wr_data update) but wr_en is forced to 0 for that cycle. This suppresses useless writes to the hard-wired zero register.
  - Not defined: address 0 is written like any other address.

## Test plan
- Reset, then req=4'b0001, addr0=5'd8, data0=32'h1234_5678 → gnt=4'b0001 the same cycle; next cycle wr_en=1, wr_addr=8, wr_data=32'h1234_5678, sel=0.
- req=4'b1111 held 4 cycles from reset → gnt sequence 0001, 0010, 0100, 1000; ptr wraps to 0; sel follows 0, 1, 2, 3 one cycle later.
- ptr=2 with req=4'b0011 → gnt=4'b0001 (scan 2, 3, 0); ptr becomes 1; next cycle gnt=4'b0010.
- stall=1 for 3 cycles after a write with req=4'b0100 → gnt=0 throughout, wr_en/wr_addr/wr_data hold; stall drops → gnt=4'b0100 that cycle.
- rst asserted mid-cycle while wr_en=1 and wr_addr=31 → wr_en=0, wr_addr=0 and sel=0 without a clock edge; after release, source 0 has first priority.
- With WB_ARB_ZERO_FILTER_EN defined, req=4'b0010, addr1=0 → gnt=4'b0010, ptr=2, wr_en stays 0; without the macro, wr_en=1 and wr_addr=0.
